dmem_io_responder: RTL and testbench

//  Data-side responder for the CPU's load/store port: byte RAM plus memory-mapped I/O for the board.

---
 rtl/dmem_io_responder_if.sv | 15 +
 rtl/dmem_io_responder.sv | 162 ++++++++++++++++
 tb/tb_dmem_io_responder.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/dmem_io_responder_if.sv
// Load/store bus between the CPU data port and dmem_io_responder.
//   ADDR   byte address (CPU ALU result)
//   WDATA  store data
//   MW     store strobe, write commits on the clock edge while high
//   Din    load data, combinational from ADDR
// master = CPU side, slave = responder side.
interface dmem_io_responder_if;
  logic [7:0] ADDR;
  logic [7:0] WDATA;
  logic       MW;
  logic [7:0] Din;

  modport master (output ADDR, output WDATA, output MW, input Din);
  modport slave  (input ADDR, input WDATA, input MW, output Din);
endinterface

// File: rtl/dmem_io_responder.sv
// dmem_io_responder: data-side responder for the CPU load/store port.
// 240-byte RAM at 00-EF plus memory-mapped board I/O at F0-F5:
//   F0 debounced button levels (RO), F1 sticky rising-edge flags (W1C),
//   F2/F3 output latches, F4 sticky game-tick flag in bit0 (W1C),
//   F5 LFSR random byte (RO). F6-FF read 0, writes ignored.
// Reads are zero latency with no side effects; a same-cycle write is not
// visible until the following cycle.
// Ports:
//   CLK, RESET_L     clock, asynchronous active-low reset
//   bus (slave)      ADDR/WDATA/MW in, Din out
//   BTN_IN[NBTN]     raw asynchronous buttons, active high
//   EN_L             CPU enable/resume strobe, registered ~btn_lvl[0]
//   OUT0, OUT1       output latches
// Build option: define DMEM_RNG_EN to build the LFSR behind F5; without it
// F5 reads 00 and no LFSR flops exist.

// Per-button debouncer: two-flop synchronizer followed by a stability
// counter. The level only moves after DB_CYCLES consecutive cycles of
// disagreement between the synced input and the current level.
module dmem_btn_db #(
  parameter logic [15:0] DB_CYCLES = 16'd50000
) (
  input  logic CLK,
  input  logic RESET_L,
  input  logic btnRaw,
  output logic btnLvl,
  output logic rise
);
  logic        sync1, sync2;
  logic [15:0] dbCnt;
  logic        hit;

  assign hit  = (sync2 != btnLvl) && (dbCnt == 16'(DB_CYCLES - 16'd1));
  // Rising pulse coincides with the edge that updates btnLvl.
  assign rise = hit & sync2;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      dbCnt  <= '0;
      btnLvl <= 1'b0;
    end else begin
      sync1 <= btnRaw;
      sync2 <= sync1;
      if (sync2 == btnLvl) begin
        dbCnt <= '0;
      end else if (hit) begin
        btnLvl <= sync2;
        dbCnt  <= '0;
      end else begin
        dbCnt <= dbCnt + 16'd1;
      end
    end
  end
endmodule

module dmem_io_responder #(
  parameter int          NBTN      = 4,
  parameter logic [15:0] DB_CYCLES = 16'd50000,
  parameter logic [23:0] TICK_DIV  = 24'd10000000,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                 CLK,
  input  logic                 RESET_L,
  dmem_io_responder_if.slave   bus,
  input  logic [NBTN-1:0]      BTN_IN,
  output logic                 EN_L,
  output logic [7:0]           OUT0,
  output logic [7:0]           OUT1
);
  localparam logic [7:0] A_LVL  = 8'hF0;
  localparam logic [7:0] A_EDGE = 8'hF1;
  localparam logic [7:0] A_OUT0 = 8'hF2;
  localparam logic [7:0] A_OUT1 = 8'hF3;
  localparam logic [7:0] A_TICK = 8'hF4;
  localparam logic [7:0] A_RNG  = 8'hF5;

  logic [NBTN-1:0] btnLvl, btnRise, btnEdge, edgeClr;
  logic [23:0]     tickCnt;
  logic            tickFlag, tickWrap, tickClr;
  logic [7:0]      rngVal;
  logic [7:0]      rdData;
  logic [7:0]      lvlByte, edgeByte;
  logic [7:0]      ram [0:239];

  for (genvar i = 0; i < NBTN; i++) begin : gBtn
    dmem_btn_db #(.DB_CYCLES(DB_CYCLES)) uDb (
      .CLK    (CLK),
      .RESET_L(RESET_L),
      .btnRaw (BTN_IN[i]),
      .btnLvl (btnLvl[i]),
      .rise   (btnRise[i])
    );
  end

  assign edgeClr  = (bus.MW && bus.ADDR == A_EDGE) ? bus.WDATA[NBTN-1:0] : '0;
  assign tickWrap = (tickCnt == 24'(TICK_DIV - 24'd1));
  assign tickClr  = bus.MW && (bus.ADDR == A_TICK) && bus.WDATA[0];

  // Sticky flags: a set in the same cycle as a W1C wins.
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      btnEdge  <= '0;
      EN_L     <= 1'b1;
      OUT0     <= '0;
      OUT1     <= '0;
      tickCnt  <= '0;
      tickFlag <= 1'b0;
    end else begin
      btnEdge  <= (btnEdge & ~edgeClr) | btnRise;
      EN_L     <= ~btnLvl[0];
      if (bus.MW && bus.ADDR == A_OUT0) OUT0 <= bus.WDATA;
      if (bus.MW && bus.ADDR == A_OUT1) OUT1 <= bus.WDATA;
      tickCnt  <= tickWrap ? 24'd0 : tickCnt + 24'd1;
      tickFlag <= (tickFlag & ~tickClr) | tickWrap;
    end
  end

  // RAM has no reset: contents survive RESET_L.
  always_ff @(posedge CLK) begin
    if (bus.MW && bus.ADDR < A_LVL) ram[bus.ADDR] <= bus.WDATA;
  end

`ifdef DMEM_RNG_EN
  // Fibonacci x^8+x^6+x^5+x^4+1, maximal length so a nonzero seed never hits 0.
  logic [7:0] lfsr;
  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) lfsr <= LFSR_SEED;
    else          lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign rngVal = lfsr;
`else
  assign rngVal = 8'h00;
`endif

  always_comb begin
    lvlByte  = '0;
    edgeByte = '0;
    lvlByte[NBTN-1:0]  = btnLvl;
    edgeByte[NBTN-1:0] = btnEdge;
  end

  always_comb begin
    rdData = 8'h00;
    if (bus.ADDR < A_LVL) begin
      rdData = ram[bus.ADDR];
    end else begin
      case (bus.ADDR)
        A_LVL:   rdData = lvlByte;
        A_EDGE:  rdData = edgeByte;
        A_OUT0:  rdData = OUT0;
        A_OUT1:  rdData = OUT1;
        A_TICK:  rdData = {7'd0, tickFlag};
        A_RNG:   rdData = rngVal;
        default: rdData = 8'h00;
      endcase
    end
  end

  assign bus.Din = rdData;
endmodule

// File: tb/tb_dmem_io_responder.sv
module tb_dmem_io_responder;
  logic       CLK = 1'b0;
  logic       RESET_L = 1'b0;
  logic [3:0] BTN_IN = 4'd0;
  logic       EN_L;
  logic [7:0] OUT0, OUT1;
  int errors = 0;
  int checks = 0;

  dmem_io_responder_if bus();

  dmem_io_responder #(
    .NBTN(4), .DB_CYCLES(16'd4), .TICK_DIV(24'd5), .LFSR_SEED(8'hA5)
  ) dut (
    .CLK(CLK), .RESET_L(RESET_L), .bus(bus), .BTN_IN(BTN_IN),
    .EN_L(EN_L), .OUT0(OUT0), .OUT1(OUT1)
  );

  always #10 CLK = ~CLK;

`ifdef DMEM_RNG_EN
  localparam logic [7:0] RNG_RST = 8'hA5;
`else
  localparam logic [7:0] RNG_RST = 8'h00;
`endif

  // Reference model of the CPU-visible byte map
  logic [7:0] ramM [0:239];
  bit         ramKnown [0:239];
  logic [7:0] out0M = 8'h00, out1M = 8'h00, lvlM = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    bus.ADDR = a;
    #1;
    d = bus.Din;
  endtask

  task automatic chkRd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    logic [7:0] d;
    rd(a, d);
    check(tag, {24'd0, d}, {24'd0, exp});
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.ADDR = a; bus.WDATA = d; bus.MW = 1'b1;
    step(1);
    bus.MW = 1'b0;
  endtask

  // Model read: returns 0 in known when the location has no defined value yet
  task automatic modelRead(input logic [7:0] a, output logic [7:0] v, output bit known);
    known = 1'b1;
    v = 8'h00;
    if (a < 8'hF0) begin
      known = ramKnown[a];
      v = ramM[a];
    end else if (a == 8'hF0) v = lvlM;
    else if (a == 8'hF2) v = out0M;
    else if (a == 8'hF3) v = out1M;
  endtask

  initial begin
    logic [7:0] a, d, v;
    bit known, doWr;
    int k;
    for (int i = 0; i < 240; i++) ramKnown[i] = 1'b0;
    bus.ADDR = 8'h00; bus.WDATA = 8'h00; bus.MW = 1'b0;

    // Reset held across edges
    step(3);
    check("rst_en_l", {31'd0, EN_L}, 32'd1);
    check("rst_out0", {24'd0, OUT0}, 32'd0);
    check("rst_out1", {24'd0, OUT1}, 32'd0);
    chkRd("rst_f1", 8'hF1, 8'h00);
    chkRd("rst_f4", 8'hF4, 8'h00);
    RESET_L = 1'b1;
    chkRd("rng_seed", 8'hF5, RNG_RST);

    // Tick: TICK_DIV=5, set on the 5th edge after reset release
    step(4);
    chkRd("tick_pre", 8'hF4, 8'h00);
    step(1);
    chkRd("tick_set", 8'hF4, 8'h01);
    wr(8'hF4, 8'h01);                 // edge 6
    chkRd("tick_clr", 8'hF4, 8'h00);
    step(3);                          // edge 9
    wr(8'hF4, 8'h01);                 // edge 10 wraps: set beats clear
    chkRd("tick_race", 8'hF4, 8'h01);
    wr(8'hF4, 8'h01);
    chkRd("tick_clr2", 8'hF4, 8'h00);

    // Button 0 / EN_L: level rises DB_CYCLES+2 = 6 edges after press
    BTN_IN[0] = 1'b1;
    step(5);
    chkRd("btn0_pre", 8'hF0, 8'h00);
    step(1);
    chkRd("btn0_lvl", 8'hF0, 8'h01);
    check("en_l_lag", {31'd0, EN_L}, 32'd1);
    chkRd("btn0_edge", 8'hF1, 8'h01);
    step(1);
    check("en_l_fall", {31'd0, EN_L}, 32'd0);
    wr(8'hF1, 8'h01);
    chkRd("edge0_clr", 8'hF1, 8'h00);

    // Button 1 bounce 1,0,1 then hold
    BTN_IN[1] = 1'b1; step(1);
    BTN_IN[1] = 1'b0; step(1);
    BTN_IN[1] = 1'b1;
    step(5);
    chkRd("btn1_pre", 8'hF0, 8'h01);
    step(1);
    chkRd("btn1_lvl", 8'hF0, 8'h03);
    chkRd("btn1_edge", 8'hF1, 8'h02);

    // Release btn1, plain W1C, then W1C racing a fresh rise
    BTN_IN[1] = 1'b0;
    step(8);
    chkRd("btn1_fall", 8'hF0, 8'h01);
    wr(8'hF1, 8'h02);
    chkRd("w1c_plain", 8'hF1, 8'h00);
    BTN_IN[1] = 1'b1;
    step(5);
    wr(8'hF1, 8'h02);                 // same edge as the new rise
    chkRd("w1c_race", 8'hF1, 8'h02);
    wr(8'hF1, 8'h02);
    chkRd("w1c_plain2", 8'hF1, 8'h00);
    lvlM = 8'h03;

    // RAM directed
    wr(8'h10, 8'h3C); ramM[8'h10] = 8'h3C; ramKnown[8'h10] = 1'b1;
    wr(8'hEF, 8'h7F); ramM[8'hEF] = 8'h7F; ramKnown[8'hEF] = 1'b1;
    chkRd("ram_10", 8'h10, 8'h3C);
    chkRd("ram_ef", 8'hEF, 8'h7F);
    bus.ADDR = 8'h10; bus.WDATA = 8'h55; bus.MW = 1'b1;
    #1;
    check("ram_old", {24'd0, bus.Din}, 32'h3C);
    step(1);
    bus.MW = 1'b0;
    ramM[8'h10] = 8'h55;
    chkRd("ram_new", 8'h10, 8'h55);

    // Randomized bus traffic against the map model
    for (int i = 0; i < 200; i++) begin
      k = $urandom_range(0, 10);
      case (k)
        7:       a = 8'hF2;
        8:       a = 8'hF3;
        9:       a = 8'($urandom_range(8'hF6, 8'hFF));
        10:      a = 8'hF0;
        default: a = 8'($urandom_range(0, 239));
      endcase
      doWr = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      modelRead(a, v, known);
      bus.ADDR = a; bus.WDATA = d; bus.MW = doWr;
      #1;
      if (known) check($sformatf("rnd_%0d_a%02h", i, a), {24'd0, bus.Din}, {24'd0, v});
      step(1);
      bus.MW = 1'b0;
      if (doWr) begin
        if (a < 8'hF0) begin ramM[a] = d; ramKnown[a] = 1'b1; end
        else if (a == 8'hF2) out0M = d;
        else if (a == 8'hF3) out1M = d;
      end
    end
    wr(8'hF2, 8'hAA);
    wr(8'hF3, 8'h5B);
    check("out0_wr", {24'd0, OUT0}, 32'hAA);
    check("out1_wr", {24'd0, OUT1}, 32'h5B);

    // Asynchronous reset mid-count, checked before any edge
    #3;
    RESET_L = 1'b0;
    #1;
    check("arst_en_l", {31'd0, EN_L}, 32'd1);
    check("arst_out0", {24'd0, OUT0}, 32'd0);
    check("arst_out1", {24'd0, OUT1}, 32'd0);
    chkRd("arst_f0", 8'hF0, 8'h00);
    chkRd("arst_f1", 8'hF1, 8'h00);
    chkRd("arst_f4", 8'hF4, 8'h00);
    chkRd("arst_ram", 8'hEF, ramM[8'hEF]);
    step(2);
    RESET_L = 1'b1;

    // RNG period: start value, 254 distinct nonzero steps, back to start at 255
    chkRd("rng_rst2", 8'hF5, RNG_RST);
`ifdef DMEM_RNG_EN
    for (int i = 1; i <= 255; i++) begin
      step(1);
      rd(8'hF5, v);
      if (i < 255) check($sformatf("rng_%0d", i), {30'd0, v != 8'h00, v != 8'hA5}, 32'd3);
      else         check("rng_period", {24'd0, v}, 32'hA5);
    end
`else
    step(7);
    chkRd("rng_off", 8'hF5, 8'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
